// File: rtl/branch_predict_unit.sv
// Branch resolution and prediction unit.
// The IF side looks up a 2-bit saturating counter table (BHT) and a tagged
// target buffer (BTB). The EX side resolves the branch, flags mispredicts,
// supplies the redirect PC, trains both tables and counts events.

package branch_predict_pkg;
  typedef enum logic [2:0] {
    BR_NOP = 3'd0,
    BR_EQ  = 3'd1,
    BR_NE  = 3'd2,
    BR_LT  = 3'd3,
    BR_GE  = 3'd4,
    BR_LTU = 3'd5,
    BR_GEU = 3'd6
  } comp_op_t;
endpackage

module branch_predict_unit
  import branch_predict_pkg::*;
#(
  parameter int         XLEN        = 32,
  parameter int         BHT_ENTRIES = 64,
  parameter logic [1:0] CTR_INIT    = 2'b01
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] if_pc,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  input  logic            ex_valid,
  input  comp_op_t        ex_comp_op,
  input  logic [XLEN-1:0] ex_operand_a,
  input  logic [XLEN-1:0] ex_operand_b,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] ex_target,
  input  logic            ex_pred_taken,
  input  logic [XLEN-1:0] ex_pred_target,
  output logic            ex_taken,
  output logic            mispredict,
  output logic [XLEN-1:0] redirect_pc,
  output logic [31:0]     stat_branches,
  output logic [31:0]     stat_mispredicts
);

  localparam int IDX_BITS = $clog2(BHT_ENTRIES);
  localparam int TAG_BITS = XLEN - IDX_BITS - 2;

  logic [1:0]          bht        [BHT_ENTRIES];
  logic                btb_valid  [BHT_ENTRIES];
  logic [TAG_BITS-1:0] btb_tag    [BHT_ENTRIES];
  logic [XLEN-1:0]     btb_target [BHT_ENTRIES];

  logic [IDX_BITS-1:0] if_idx;
  logic [TAG_BITS-1:0] if_tag;
  logic [IDX_BITS-1:0] ex_idx;
  logic [TAG_BITS-1:0] ex_tag;
  logic                train;

  // PC bits [1:0] never select an entry; fold them away explicitly.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{if_pc[1:0], ex_pc[1:0]};

  assign if_idx = if_pc[IDX_BITS+1:2];
  assign if_tag = if_pc[XLEN-1:IDX_BITS+2];
  assign ex_idx = ex_pc[IDX_BITS+1:2];
  assign ex_tag = ex_pc[XLEN-1:IDX_BITS+2];
  assign train  = ex_valid && (ex_comp_op != BR_NOP);

  // IF lookup: a hit needs a valid, tag-matching BTB entry and a taken-leaning counter.
  always_comb begin
    pred_taken  = btb_valid[if_idx] && (btb_tag[if_idx] == if_tag) && bht[if_idx][1];
    pred_target = pred_taken ? btb_target[if_idx] : '0;
  end

  // EX resolution: the comparison only matters for a live, real branch.
  always_comb begin
    ex_taken = 1'b0;
    if (ex_valid) begin
      case (ex_comp_op)
        BR_EQ:   ex_taken = (ex_operand_a == ex_operand_b);
        BR_NE:   ex_taken = (ex_operand_a != ex_operand_b);
        BR_LT:   ex_taken = ($signed(ex_operand_a) <  $signed(ex_operand_b));
        BR_GE:   ex_taken = ($signed(ex_operand_a) >= $signed(ex_operand_b));
        BR_LTU:  ex_taken = (ex_operand_a <  ex_operand_b);
        BR_GEU:  ex_taken = (ex_operand_a >= ex_operand_b);
        default: ex_taken = 1'b0;
      endcase
    end
  end

  // Wrong direction, or right direction to the wrong place; a predicted-taken NOP counts too.
  always_comb begin
    mispredict  = ex_valid &&
                  ((ex_taken != ex_pred_taken) ||
                   (ex_taken && ex_pred_taken && (ex_pred_target != ex_target)));
    redirect_pc = ex_taken ? ex_target : ex_pc + XLEN'(4);
  end

  // Table training; lookups above see the old contents until the next cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BHT_ENTRIES; i++) begin
        bht[i]        <= CTR_INIT;
        btb_valid[i]  <= 1'b0;
        btb_tag[i]    <= '0;
        btb_target[i] <= '0;
      end
    end else if (train) begin
      if (ex_taken) begin
        if (bht[ex_idx] != 2'b11) bht[ex_idx] <= bht[ex_idx] + 2'b01;
        btb_valid[ex_idx]  <= 1'b1;
        btb_tag[ex_idx]    <= ex_tag;
        btb_target[ex_idx] <= ex_target;
      end else begin
        if (bht[ex_idx] != 2'b00) bht[ex_idx] <= bht[ex_idx] - 2'b01;
      end
    end
  end

  // Performance counters, free-running and wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else begin
      if (train)      stat_branches    <= stat_branches + 32'd1;
      if (mispredict) stat_mispredicts <= stat_mispredicts + 32'd1;
    end
  end

endmodule

// File: tb/tb_branch_predict_unit.sv
// Self-checking bench for branch_predict_unit with a table-level reference model.

module tb_branch_predict_unit;
  import branch_predict_pkg::*;

  localparam int N    = 64;
  localparam int SPAN = 4 * N;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] if_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        ex_valid;
  comp_op_t    ex_comp_op;
  logic [31:0] ex_operand_a, ex_operand_b, ex_pc, ex_target, ex_pred_target;
  logic        ex_pred_taken;
  logic        ex_taken, mispredict;
  logic [31:0] redirect_pc, stat_branches, stat_mispredicts;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  int          m_ctr [N];
  bit          m_v   [N];
  logic [31:0] m_pc  [N];
  logic [31:0] m_tgt [N];
  logic [31:0] m_br, m_mp;

  branch_predict_unit dut (
    .clk(clk), .rst(rst), .if_pc(if_pc),
    .pred_taken(pred_taken), .pred_target(pred_target),
    .ex_valid(ex_valid), .ex_comp_op(ex_comp_op),
    .ex_operand_a(ex_operand_a), .ex_operand_b(ex_operand_b),
    .ex_pc(ex_pc), .ex_target(ex_target),
    .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
    .ex_taken(ex_taken), .mispredict(mispredict), .redirect_pc(redirect_pc),
    .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  function automatic int idx_of(logic [31:0] pc);
    return int'((pc / 4) % N);
  endfunction

  function automatic bit m_pred(logic [31:0] pc);
    int i = idx_of(pc);
    return m_v[i] && ((m_pc[i] / SPAN) == (pc / SPAN)) && (m_ctr[i] >= 2);
  endfunction

  function automatic logic [31:0] m_pred_tgt(logic [31:0] pc);
    return m_pred(pc) ? m_tgt[idx_of(pc)] : 32'd0;
  endfunction

  function automatic longint to_signed(logic [31:0] v);
    return v[31] ? longint'(v) - 64'sd4294967296 : longint'(v);
  endfunction

  function automatic bit m_taken(bit v, comp_op_t op, logic [31:0] a, logic [31:0] b);
    if (!v) return 1'b0;
    case (op)
      BR_EQ:  return a == b;
      BR_NE:  return a != b;
      BR_LT:  return to_signed(a) < to_signed(b);
      BR_GE:  return to_signed(a) >= to_signed(b);
      BR_LTU: return longint'(a) < longint'(b);
      BR_GEU: return longint'(a) >= longint'(b);
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit m_misp(bit v, bit t, bit pt, logic [31:0] ptgt, logic [31:0] tgt);
    return v && ((t != pt) || (t && pt && ptgt != tgt));
  endfunction

  task automatic m_reset();
    for (int i = 0; i < N; i++) begin
      m_ctr[i] = 1; m_v[i] = 0; m_pc[i] = 0; m_tgt[i] = 0;
    end
    m_br = 0; m_mp = 0;
  endtask

  task automatic drive(bit v, comp_op_t op, logic [31:0] a, logic [31:0] b, logic [31:0] pc,
                       logic [31:0] tgt, bit pt, logic [31:0] ptgt);
    ex_valid = v; ex_comp_op = op; ex_operand_a = a; ex_operand_b = b;
    ex_pc = pc; ex_target = tgt; ex_pred_taken = pt; ex_pred_target = ptgt;
  endtask

  task automatic idle();
    drive(1'b0, BR_NOP, 0, 0, 0, 0, 1'b0, 0);
  endtask

  // advance one clock, updating the model with what the DUT sees at the edge
  task automatic tick();
    bit t, mp;
    int i;
    t  = m_taken(ex_valid, ex_comp_op, ex_operand_a, ex_operand_b);
    mp = m_misp(ex_valid, t, ex_pred_taken, ex_pred_target, ex_target);
    @(posedge clk);
    if (rst) m_reset();
    else begin
      if (ex_valid && ex_comp_op != BR_NOP) begin
        i = idx_of(ex_pc);
        if (t) begin
          m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
          m_v[i] = 1; m_pc[i] = ex_pc; m_tgt[i] = ex_target;
        end else m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
        m_br = m_br + 1;
      end
      if (mp) m_mp = m_mp + 1;
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; idle(); tick(); rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    if_pc = $urandom(); #1;
    n_tests++; if (pred_taken !== 1'b0) begin n_fail++; $display("FAIL reset_pred_taken: got %b expected 0", pred_taken); end
    n_tests++; if (pred_target !== 32'd0) begin n_fail++; $display("FAIL reset_pred_target: got %h expected 0", pred_target); end
    n_tests++; if (stat_branches !== 32'd0) begin n_fail++; $display("FAIL reset_stat_br: got %0d expected 0", stat_branches); end
    n_tests++; if (stat_mispredicts !== 32'd0) begin n_fail++; $display("FAIL reset_stat_mp: got %0d expected 0", stat_mispredicts); end
  endtask

  task automatic test_train_basic();
    drive(1'b1, BR_EQ, 7, 7, 32'h100, 32'h200, 1'b0, 0); #1;
    n_tests++; if (ex_taken !== 1'b1) begin n_fail++; $display("FAIL basic_taken: got %b expected 1", ex_taken); end
    n_tests++; if (mispredict !== 1'b1) begin n_fail++; $display("FAIL basic_misp: got %b expected 1", mispredict); end
    n_tests++; if (redirect_pc !== 32'h200) begin n_fail++; $display("FAIL basic_redirect: got %h expected 200", redirect_pc); end
    tick(); idle(); if_pc = 32'h100; #1;
    n_tests++; if (pred_taken !== 1'b1) begin n_fail++; $display("FAIL basic_pred: got %b expected 1", pred_taken); end
    n_tests++; if (pred_target !== 32'h200) begin n_fail++; $display("FAIL basic_pred_tgt: got %h expected 200", pred_target); end
    n_tests++; if (stat_branches !== 32'd1) begin n_fail++; $display("FAIL basic_stat_br: got %0d expected 1", stat_branches); end
    n_tests++; if (stat_mispredicts !== 32'd1) begin n_fail++; $display("FAIL basic_stat_mp: got %0d expected 1", stat_mispredicts); end
  endtask

  task automatic test_signed_unsigned();
    comp_op_t ops [4] = '{BR_LT, BR_LTU, BR_GE, BR_GEU};
    bit       exp [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, ops[k], 32'hFFFF_FFFF, 32'd5, 32'h40, 32'h80, 1'b0, 0); #1;
      n_tests++; if (ex_taken !== exp[k]) begin n_fail++; $display("FAIL cmp_%s: got %b expected %b", ops[k].name(), ex_taken, exp[k]); end
      if (ops[k] == BR_LTU) begin
        n_tests++; if (redirect_pc !== 32'h44) begin n_fail++; $display("FAIL ltu_redirect: got %h expected 44", redirect_pc); end
      end
    end
    drive(1'b1, BR_NE, 3, 3, 32'hFFFF_FFFC, 32'h80, 1'b0, 0); #1;
    n_tests++; if (redirect_pc !== 32'h0) begin n_fail++; $display("FAIL wrap_redirect: got %h expected 0", redirect_pc); end
    drive(1'b0, BR_EQ, 3, 3, 32'h40, 32'h80, 1'b0, 0); #1;
    n_tests++; if (ex_taken !== 1'b0) begin n_fail++; $display("FAIL invalid_taken: got %b expected 0", ex_taken); end
    idle();
  endtask

  task automatic test_saturation_alias();
    bit exp_pred [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    do_reset();
    if_pc = 32'h100;
    for (int k = 0; k < 6; k++) begin
      if (k < 4) drive(1'b1, BR_EQ, 1, 1, 32'h100, 32'h200, 1'b0, 0);
      else       drive(1'b1, BR_EQ, 1, 2, 32'h100, 32'h200, 1'b0, 0);
      tick(); idle(); #1;
      n_tests++; if (pred_taken !== exp_pred[k]) begin n_fail++; $display("FAIL sat_step%0d: got %b expected %b", k, pred_taken, exp_pred[k]); end
    end
    drive(1'b1, BR_EQ, 1, 1, 32'h100, 32'h200, 1'b0, 0); tick(); idle();
    if_pc = 32'h100 + SPAN; #1;
    n_tests++; if (pred_taken !== 1'b0) begin n_fail++; $display("FAIL alias_pred: got %b expected 0", pred_taken); end
    n_tests++; if (pred_target !== 32'h0) begin n_fail++; $display("FAIL alias_tgt: got %h expected 0", pred_target); end
  endtask

  task automatic test_target_collision();
    // counter at 0x100 is 10 from the previous task
    drive(1'b1, BR_EQ, 9, 9, 32'h100, 32'h200, 1'b1, 32'h300); #1;
    n_tests++; if (mispredict !== 1'b1) begin n_fail++; $display("FAIL tgt_misp: got %b expected 1", mispredict); end
    n_tests++; if (redirect_pc !== 32'h200) begin n_fail++; $display("FAIL tgt_redirect: got %h expected 200", redirect_pc); end
    tick();                                                  // 10 -> 11
    drive(1'b1, BR_NE, 9, 9, 32'h100, 32'h200, 1'b1, 32'h200); tick(); // 11 -> 10
    if_pc = 32'h100;
    drive(1'b1, BR_NE, 9, 9, 32'h100, 32'h200, 1'b1, 32'h200); #1;      // 10 -> 01 at edge
    n_tests++; if (pred_taken !== 1'b1) begin n_fail++; $display("FAIL collide_old: got %b expected 1", pred_taken); end
    tick(); idle(); #1;
    n_tests++; if (pred_taken !== 1'b0) begin n_fail++; $display("FAIL collide_new: got %b expected 0", pred_taken); end
  endtask

  task automatic test_nop_mispredict();
    logic [31:0] br0, mp0;
    br0 = stat_branches; mp0 = stat_mispredicts;
    drive(1'b1, BR_NOP, 1, 1, 32'h500, 32'h600, 1'b1, 32'h600); #1;
    n_tests++; if (ex_taken !== 1'b0) begin n_fail++; $display("FAIL nop_taken: got %b expected 0", ex_taken); end
    n_tests++; if (mispredict !== 1'b1) begin n_fail++; $display("FAIL nop_misp: got %b expected 1", mispredict); end
    n_tests++; if (redirect_pc !== 32'h504) begin n_fail++; $display("FAIL nop_redirect: got %h expected 504", redirect_pc); end
    tick(); idle(); #1;
    n_tests++; if (stat_branches !== br0) begin n_fail++; $display("FAIL nop_stat_br: got %0d expected %0d", stat_branches, br0); end
    n_tests++; if (stat_mispredicts !== mp0 + 32'd1) begin n_fail++; $display("FAIL nop_stat_mp: got %0d expected %0d", stat_mispredicts, mp0 + 32'd1); end
  endtask

  task automatic test_reset_mid();
    drive(1'b1, BR_EQ, 1, 1, 32'h100, 32'h200, 1'b0, 0); tick(); tick(); // entry strongly taken
    rst = 1'b1;
    drive(1'b1, BR_EQ, 1, 1, 32'h100, 32'h200, 1'b0, 0);
    tick(); rst = 1'b0; idle();
    if_pc = 32'h100; #1;
    n_tests++; if (pred_taken !== 1'b0) begin n_fail++; $display("FAIL midrst_pred: got %b expected 0", pred_taken); end
    n_tests++; if (stat_branches !== 32'd0) begin n_fail++; $display("FAIL midrst_stat_br: got %0d expected 0", stat_branches); end
    n_tests++; if (stat_mispredicts !== 32'd0) begin n_fail++; $display("FAIL midrst_stat_mp: got %0d expected 0", stat_mispredicts); end
  endtask

  task automatic test_random();
    logic [31:0] vals [4] = '{32'd0, 32'd5, 32'h8000_0000, 32'hFFFF_FFFF};
    logic [31:0] pc, tgt, e_red;
    bit          v, pt, e_t, e_mp, e_pt;
    comp_op_t    op;
    do_reset();
    for (int k = 0; k < 400; k++) begin
      pc  = 32'($urandom_range(0, 3)) * SPAN + 32'($urandom_range(0, 7)) * 4 + 32'($urandom_range(0, 3));
      tgt = 32'h1000 + 32'($urandom_range(0, 3)) * 4;
      v   = ($urandom_range(0, 9) != 0);
      op  = comp_op_t'(3'($urandom_range(0, 6)));
      if ($urandom_range(0, 1) == 1) begin
        pt = m_pred(pc);
        drive(v, op, vals[$urandom_range(0, 3)], vals[$urandom_range(0, 3)], pc, tgt, pt, m_pred_tgt(pc));
      end else begin
        pt = 1'($urandom_range(0, 1));
        drive(v, op, vals[$urandom_range(0, 3)], vals[$urandom_range(0, 3)], pc, tgt, pt,
              ($urandom_range(0, 1) == 1) ? tgt : 32'h1000 + 32'($urandom_range(0, 3)) * 4);
      end
      if_pc = ($urandom_range(0, 2) == 0) ? pc : 32'($urandom_range(0, 3)) * SPAN + 32'($urandom_range(0, 7)) * 4;
      #1;
      e_t   = m_taken(v, op, ex_operand_a, ex_operand_b);
      e_mp  = m_misp(v, e_t, ex_pred_taken, ex_pred_target, tgt);
      e_red = e_t ? tgt : pc + 32'd4;
      e_pt  = m_pred(if_pc);
      n_tests++; if (ex_taken !== e_t) begin n_fail++; $display("FAIL rnd%0d_taken: got %b expected %b", k, ex_taken, e_t); end
      n_tests++; if (mispredict !== e_mp) begin n_fail++; $display("FAIL rnd%0d_misp: got %b expected %b", k, mispredict, e_mp); end
      n_tests++; if (redirect_pc !== e_red) begin n_fail++; $display("FAIL rnd%0d_redirect: got %h expected %h", k, redirect_pc, e_red); end
      n_tests++; if (pred_taken !== e_pt) begin n_fail++; $display("FAIL rnd%0d_pred: got %b expected %b", k, pred_taken, e_pt); end
      n_tests++; if (pred_target !== m_pred_tgt(if_pc)) begin n_fail++; $display("FAIL rnd%0d_pred_tgt: got %h expected %h", k, pred_target, m_pred_tgt(if_pc)); end
      tick();
    end
    idle(); #1;
    n_tests++; if (stat_branches !== m_br) begin n_fail++; $display("FAIL rnd_stat_br: got %0d expected %0d", stat_branches, m_br); end
    n_tests++; if (stat_mispredicts !== m_mp) begin n_fail++; $display("FAIL rnd_stat_mp: got %0d expected %0d", stat_mispredicts, m_mp); end
  endtask

  initial begin
    rst = 1'b1; if_pc = 0; idle();
    m_reset();
    @(negedge clk);
    test_reset();
    test_train_basic();
    test_signed_unsigned();
    test_saturation_alias();
    test_target_collision();
    test_nop_mispredict();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_predict_unit.md
Name: branch_predict_unit

Overview:
- Parametrised successor to the combinational branch comparator: resolves conditional branches in EX and also predicts them in IF.
- Prediction uses a direct-mapped table of 2-bit saturating counters (BHT) plus a tagged branch target buffer (BTB).
- In EX it evaluates the comparison, detects a misprediction, supplies the redirect PC, trains both tables and keeps performance counters.

Parameters:
- XLEN, 32, datapath/PC width.
- BHT_ENTRIES, 64, number of BHT and BTB entries; power of two, ≥2. IDX_BITS = log2(BHT_ENTRIES).
- CTR_INIT, 2'b01, counter reset value (weakly not-taken).

Ports:
- clk  in  1  system clock, all state updates on the rising edge
- rst  in  1  synchronous reset, active-high
- if_pc  in  XLEN  fetch PC to predict
- pred_taken  out  1  IF prediction (combinational)
- pred_target  out  XLEN  predicted target; valid when pred_taken=1, else 0
- ex_valid  in  1  real, unflushed, unstalled instruction in EX this cycle
- ex_comp_op  in  comp_op_t  BR_EQ/NE/LT/GE/LTU/GEU/BR_NOP
- ex_operand_a  in  XLEN  rs1 value
- ex_operand_b  in  XLEN  rs2 value
- ex_pc  in  XLEN  PC of the EX instruction
- ex_target  in  XLEN  computed branch target
- ex_pred_taken  in  1  pred_taken carried down from IF
- ex_pred_target  in  XLEN  pred_target carried down from IF
- ex_taken  out  1  resolved outcome (combinational)
- mispredict  out  1  flush/redirect request (combinational)
- redirect_pc  out  XLEN  correct next PC
- stat_branches  out  32  count of resolved branches
- stat_mispredicts  out  32  count of mispredicts

Behaviour:
- Index is pc[IDX_BITS+1:2]. Tag is pc[XLEN-1:IDX_BITS+2]. PC bits [1:0] are ignored.
- Prediction: pred_taken = btb_valid[idx] && btb_tag[idx]==tag && bht[idx][1]. pred_target = btb_target[idx] when pred_taken, else 0.
- Comparison: ex_taken is computed only when ex_valid and the op is not BR_NOP; otherwise 0.
  - EQ/NE use equality.
  - LT/GE use a signed XLEN compare.
  - LTU/GEU use an unsigned compare.
- Mispredict: mispredict = ex_valid && ( ex_taken != ex_pred_taken || (ex_taken && ex_pred_taken && ex_pred_target != ex_target) ).
  - ex_valid with BR_NOP while ex_pred_taken=1 is a mispredict with ex_taken=0.
- redirect_pc = ex_taken ? ex_target : ex_pc+4. The +4 wraps modulo 2^XLEN. redirect_pc is always driven; the consumer uses it only when mispredict=1.
- Training (clock edge, only when ex_valid && op≠BR_NOP, using the ex_pc index):
  - Taken: bht increments, saturating at 11. BTB entry is written with valid=1, tag and ex_target.
  - Not taken: bht decrements, saturating at 00. BTB entry is left unchanged.
- Same-index collision: if IF reads the index EX writes in the same cycle, IF sees the pre-update value (read-before-write). The new value is visible next cycle.
- Stats (clock edge, wrap modulo 2^32):
  - stat_branches increments on each training event.
  - stat_mispredicts increments whenever mispredict=1, BR_NOP case included.
- Reset (synchronous, takes priority over training, including mid-training):
  - All bht entries = CTR_INIT.
  - All btb_valid = 0; btb_tag/target = 0.
  - Both stat counters = 0.
  - Comb outputs after reset: pred_taken=0, pred_target=0.
- Latency: prediction and resolution are zero-cycle combinational. Table effects appear one cycle after the training edge.

Test Plan:
- Reset, then any if_pc → pred_taken=0, pred_target=0. Stat counters read 0.
- Train ex_pc=0x100, BR_EQ, a=b=7, target=0x200, ex_pred_taken=0 → ex_taken=1, mispredict=1, redirect_pc=0x200. Next cycle if_pc=0x100 → pred_taken=1 (counter 10), pred_target=0x200. stat_branches=1, stat_mispredicts=1.
- Signed/unsigned at pc=0x40, a=0xFFFFFFFF, b=5:
  - BR_LT → ex_taken=1.
  - BR_LTU → ex_taken=0, redirect_pc=0x44.
  - BR_GE → ex_taken=0.
  - BR_GEU → ex_taken=1.
- Saturation and aliasing: train pc=0x100 taken ×4, then not-taken ×1 → pred_taken stays 1 (counter 10); second not-taken → 0. Then if_pc=0x100+4·BHT_ENTRIES (0x200 when BHT_ENTRIES=64) → tag mismatch → pred_taken=0.
- Target and collision cases:
  - ex_pred_taken=1, ex_pred_target=0x300, ex_target=0x200, taken → mispredict=1, redirect_pc=0x200.
  - Same-cycle if_pc==ex_pc update → pred_taken reflects the old counter; the new counter is visible next cycle.
- Reset mid-operation: assert rst in the same cycle as a taken training event → the entry is not written, stats=0, next-cycle pred_taken=0.
